// File: rtl/mmm_mod_inv_kal_if.sv
// Operand/result handshake bundle for the Kaliski modular-inverse engine.
// The master side supplies operands and accepts results; the slave side is the engine.
interface mmm_mod_inv_kal_if #(
  parameter int W  = 256,
  parameter int KW = $clog2(2*W+1)
);
  logic          i_valid;
  logic          o_ready;
  logic [1:0]    i_mode;
  logic [W-1:0]  i_a;
  logic [W-1:0]  i_p;
  logic          o_valid;
  logic          i_ready;
  logic [W-1:0]  o_res;
  logic [KW-1:0] o_k;
  logic          o_err;

  modport master (
    output i_valid, i_mode, i_a, i_p, i_ready,
    input  o_ready, o_valid, o_res, o_k, o_err
  );

  modport slave (
    input  i_valid, i_mode, i_a, i_p, i_ready,
    output o_ready, o_valid, o_res, o_k, o_err
  );
endinterface

// File: rtl/mmm_mod_inv_kal.sv
// Kaliski almost-Montgomery-inverse engine: phase 1 yields a^-1*2^k mod p,
// phase 2 rescales to the plain inverse or the Montgomery-domain inverse.
module mmm_mod_inv_kal #(
  parameter int W  = 256,
  parameter int KW = $clog2(2*W+1)
) (
  input  logic              i_clk,
  input  logic              i_rstn,
  mmm_mod_inv_kal_if.slave  bus
);

  typedef enum logic [2:0] {IDLE, PH1, FIX, PH2, DONE} state_t;

  state_t        state, state_nx;
  logic [W-1:0]  u, u_nx, v, v_nx, p_q, p_nx;
  logic [W:0]    r, r_nx, s, s_nx;
  logic [KW-1:0] k, k_nx, h, h_nx;
  logic [1:0]    mode_q, mode_nx;
  logic          dbl, dbl_nx;
  logic          err_q, err_nx;
  logic          ld_out;
  logic [W-1:0]  res_q;
  logic [KW-1:0] k_out_q;
  logic          err_out_q;

  function automatic logic [W:0] half_mod(input logic [W:0] x, input logic [W-1:0] m);
    logic [W:0] t;
    t = x[0] ? x + {1'b0, m} : x;
    return t >> 1;
  endfunction

  function automatic logic [W:0] dbl_mod(input logic [W:0] x, input logic [W-1:0] m);
    logic [W:0] t;
    t = {x[W-1:0], 1'b0};
    if (t >= {1'b0, m}) t = t - {1'b0, m};
    return t;
  endfunction

  // Phase-1 r may reach p; fold it into [0,p) and negate to get a^-1*2^k mod p
  function automatic logic [W:0] fix_r(input logic [W:0] x, input logic [W-1:0] m);
    logic [W:0] t;
    t = (x >= {1'b0, m}) ? x - {1'b0, m} : x;
    return {1'b0, m} - t;
  endfunction

  always_comb begin
    state_nx = state;
    u_nx     = u;
    v_nx     = v;
    r_nx     = r;
    s_nx     = s;
    k_nx     = k;
    h_nx     = h;
    dbl_nx   = dbl;
    p_nx     = p_q;
    mode_nx  = mode_q;
    err_nx   = err_q;
    ld_out   = 1'b0;
    case (state)
      IDLE: begin
        if (bus.i_valid) begin
          p_nx    = bus.i_p;
          mode_nx = bus.i_mode;
          u_nx    = bus.i_p;
          v_nx    = bus.i_a;
          r_nx    = '0;
          s_nx    = {{W{1'b0}}, 1'b1};
          k_nx    = '0;
          err_nx  = (bus.i_a == '0) || !bus.i_p[0] || (bus.i_mode == 2'd3);
          // Bad operands take one FIX cycle, which reports the error
          state_nx = err_nx ? FIX : PH1;
        end
      end
      PH1: begin
        if (v == '0) begin
          state_nx = FIX;
        end else begin
          k_nx = k + KW'(1);
          if (!u[0]) begin
            u_nx = u >> 1;
            s_nx = s << 1;
          end else if (!v[0]) begin
            v_nx = v >> 1;
            r_nx = r << 1;
          end else if (u > v) begin
            u_nx = (u - v) >> 1;
            r_nx = r + s;
            s_nx = s << 1;
          end else begin
            v_nx = (v - u) >> 1;
            s_nx = s + r;
            r_nx = r << 1;
          end
          if (v_nx == '0) state_nx = FIX;
        end
      end
      FIX: begin
        if (err_q || (u != {{(W-1){1'b0}}, 1'b1})) begin
          err_nx   = 1'b1;
          r_nx     = '0;
          ld_out   = 1'b1;
          state_nx = DONE;
        end else begin
          r_nx   = fix_r(r, p_q);
          dbl_nx = (mode_q == 2'd2) && (k < KW'(W));
          case (mode_q)
            2'd1:    h_nx = k;
            2'd2:    h_nx = (k >= KW'(W)) ? k - KW'(W) : KW'(W) - k;
            default: h_nx = '0;
          endcase
          state_nx = PH2;
        end
      end
      PH2: begin
        if (h == '0) begin
          ld_out   = 1'b1;
          state_nx = DONE;
        end else begin
          r_nx = dbl ? dbl_mod(r, p_q) : half_mod(r, p_q);
          h_nx = h - KW'(1);
        end
      end
      DONE: begin
        if (bus.i_ready) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      state     <= IDLE;
      err_q     <= 1'b0;
      res_q     <= '0;
      k_out_q   <= '0;
      err_out_q <= 1'b0;
    end else begin
      state <= state_nx;
      err_q <= err_nx;
      if (ld_out) begin
        res_q     <= r_nx[W-1:0];
        k_out_q   <= k;
        err_out_q <= err_nx;
      end
    end
  end

  always_ff @(posedge i_clk) begin
    u      <= u_nx;
    v      <= v_nx;
    r      <= r_nx;
    s      <= s_nx;
    k      <= k_nx;
    h      <= h_nx;
    dbl    <= dbl_nx;
    p_q    <= p_nx;
    mode_q <= mode_nx;
  end

  assign bus.o_ready = (state == IDLE);
  assign bus.o_valid = (state == DONE);
  assign bus.o_res   = res_q;
  assign bus.o_k     = k_out_q;
  assign bus.o_err   = err_out_q;

endmodule

// File: tb/tb_mmm_mod_inv_kal.sv
// Directed bench for mmm_mod_inv_kal: W=8 timing/error/backpressure/reset
// vectors, a small W=8 model-checked sweep, and W=256 directed vectors.
module tb_mmm_mod_inv_kal;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  int   checks = 0;
  int   fails = 0;

  always #5 clk = ~clk;

  mmm_mod_inv_kal_if #(.W(8))   if8 ();
  mmm_mod_inv_kal_if #(.W(256)) if256 ();

  mmm_mod_inv_kal #(.W(8))   dut8   (.i_clk(clk), .i_rstn(rstn), .bus(if8));
  mmm_mod_inv_kal #(.W(256)) dut256 (.i_clk(clk), .i_rstn(rstn), .bus(if256));

  task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
    checks++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic send8(input logic [1:0] m, input logic [7:0] a, input logic [7:0] p);
    @(negedge clk);
    if8.i_mode  = m;
    if8.i_a     = a;
    if8.i_p     = p;
    if8.i_valid = 1'b1;
    @(posedge clk);
    #1 if8.i_valid = 1'b0;
  endtask

  task automatic wait8(output int n);
    n = 0;
    do begin
      @(posedge clk);
      n++;
      #1;
    end while (!if8.o_valid && n < 3000);
    if (!if8.o_valid) n = -1;
  endtask

  task automatic accept8();
    if8.i_ready = 1'b1;
    @(posedge clk);
    #1 if8.i_ready = 1'b0;
  endtask

  task automatic txn8(input string tag, input logic [1:0] m, input int a, input int p,
                      input int exp_res, input int exp_k, input bit exp_err, input int exp_lat);
    int n;
    send8(m, 8'(a), 8'(p));
    wait8(n);
    chk({tag, "_lat"}, 256'(n), 256'(exp_lat));
    chk({tag, "_res"}, 256'(if8.o_res), 256'(exp_res));
    chk({tag, "_k"},   256'(if8.o_k), 256'(exp_k));
    chk({tag, "_err"}, 256'(if8.o_err), 256'(exp_err));
    accept8();
    chk({tag, "_rdy"}, 256'({if8.o_ready, if8.o_valid}), 256'(2'b10));
  endtask

  task automatic txn256(input string tag, input logic [1:0] m, input logic [255:0] a,
                        input logic [255:0] p, input logic [255:0] exp_res);
    int n;
    @(negedge clk);
    if256.i_mode  = m;
    if256.i_a     = a;
    if256.i_p     = p;
    if256.i_valid = 1'b1;
    @(posedge clk);
    #1 if256.i_valid = 1'b0;
    n = 0;
    do begin
      @(posedge clk);
      n++;
      #1;
    end while (!if256.o_valid && n < 3000);
    chk({tag, "_vld"}, 256'(if256.o_valid), 256'(1));
    chk({tag, "_res"}, if256.o_res, exp_res);
    chk({tag, "_err"}, 256'(if256.o_err), 256'(0));
    if256.i_ready = 1'b1;
    @(posedge clk);
    #1 if256.i_ready = 1'b0;
  endtask

  // Reference: Kaliski phase-1 iteration count on plain integers
  function automatic int kal_k(input int a, input int p);
    int u, v, r, s, k;
    u = p; v = a; r = 0; s = 1; k = 0;
    while (v != 0) begin
      k++;
      if (u % 2 == 0)      begin u = u / 2; s = 2 * s; end
      else if (v % 2 == 0) begin v = v / 2; r = 2 * r; end
      else if (u > v)      begin u = (u - v) / 2; r = r + s; s = 2 * s; end
      else                 begin v = (v - u) / 2; s = s + r; r = 2 * r; end
    end
    return k;
  endfunction

  function automatic int inv_mod(input int a, input int p);
    for (int x = 1; x < p; x++) if ((a * x) % p == 1) return x;
    return 0;
  endfunction

  function automatic int pow2_mod(input int e, input int p);
    int x;
    x = 1;
    for (int i = 0; i < e; i++) x = (2 * x) % p;
    return x;
  endfunction

  initial begin
    #900000;
    $display("FAIL watchdog got=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int primes[5] = '{13, 251, 97, 211, 3};
    logic [255:0] p25519;

    if8.i_valid = 1'b0; if8.i_ready = 1'b0; if8.i_mode = '0; if8.i_a = '0; if8.i_p = '0;
    if256.i_valid = 1'b0; if256.i_ready = 1'b0; if256.i_mode = '0; if256.i_a = '0; if256.i_p = '0;

    #12;
    chk("rst_rdy8", 256'({if8.o_ready, if8.o_valid, if8.o_err}), 256'(3'b100));
    chk("rst_res8", 256'({if8.o_res, if8.o_k}), 256'(0));
    chk("rst_256",  256'({if256.o_ready, if256.o_valid, if256.o_err}), 256'(3'b100));
    @(negedge clk);
    rstn = 1'b1;

    txn8("m0_3_13", 2'd0, 3, 13, 1, 4, 1'b0, 6);
    txn8("m1_3_13", 2'd1, 3, 13, 9, 4, 1'b0, 10);
    txn8("m2_3_13", 2'd2, 3, 13, 3, 4, 1'b0, 10);
    txn8("noinv",   2'd1, 6, 15, 0, 4, 1'b1, 5);
    txn8("a_zero",  2'd1, 0, 13, 0, 0, 1'b1, 1);
    txn8("p_even",  2'd1, 3, 14, 0, 0, 1'b1, 1);
    txn8("mode3",   2'd3, 3, 13, 0, 0, 1'b1, 1);

    // Backpressure: result held, new request waits for o_ready
    send8(2'd0, 8'd3, 8'd13);
    wait8(n);
    chk("bp_lat", 256'(n), 256'(6));
    if8.i_mode = 2'd1; if8.i_a = 8'd5; if8.i_p = 8'd13; if8.i_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      chk("bp_hold", 256'({if8.o_valid, if8.o_ready, if8.o_res, if8.o_k}),
          256'({1'b1, 1'b0, 8'd1, 5'd4}));
    end
    if8.i_ready = 1'b1;
    @(posedge clk);
    #1 if8.i_ready = 1'b0;
    chk("bp_release", 256'({if8.o_ready, if8.o_valid}), 256'(2'b10));
    @(posedge clk);
    #1 if8.i_valid = 1'b0;
    chk("bp_accept", 256'(if8.o_ready), 256'(0));
    wait8(n);
    chk("bp2_lat", 256'(n), 256'(14));
    chk("bp2_res", 256'({if8.o_res, if8.o_k, if8.o_err}), 256'({8'd8, 5'd6, 1'b0}));
    accept8();

    // W=8 sweep against the integer model
    for (int i = 0; i < 24; i++) begin
      int p, a, m, k, h, iv, er;
      p  = primes[$urandom_range(0, 4)];
      a  = $urandom_range(1, p - 1);
      m  = $urandom_range(0, 2);
      k  = kal_k(a, p);
      iv = inv_mod(a, p);
      if (m == 0)      begin h = 0; er = (iv * pow2_mod(k, p)) % p; end
      else if (m == 1) begin h = k; er = iv; end
      else             begin h = (k >= 8) ? k - 8 : 8 - k; er = (iv * pow2_mod(8, p)) % p; end
      txn8("rnd", 2'(m), a, p, er, k, 1'b0, k + h + 2);
    end

    p25519 = (256'(1) << 255) - 256'(19);
    txn256("w256_m1", 2'd1, 256'(2), p25519, (256'(1) << 254) - 256'(9));
    txn256("w256_m2", 2'd2, 256'(2), p25519, 256'(19));

    // Reset in the middle of phase 1
    send8(2'd1, 8'd3, 8'd13);
    @(posedge clk);
    @(posedge clk);
    #1 rstn = 1'b0;
    #1;
    chk("mid_rst_ctl", 256'({if8.o_ready, if8.o_valid, if8.o_err}), 256'(3'b100));
    chk("mid_rst_dat", 256'({if8.o_res, if8.o_k}), 256'(0));
    @(negedge clk);
    rstn = 1'b1;
    txn8("post_rst", 2'd1, 3, 13, 9, 4, 1'b0, 10);

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule
